ctrl_pipe_chain: RTL and testbench
==================================

# ctrl_pipe_chain

Parametrised control-signal pipeline for the pipelined RISC-V core. It carries a decoded control word plus a valid bit from decode through `STAGES` register stages (E, M, W, …). Each stage has its own stall and flush; stalls propagate upstream automatically and bubbles are inserted downstream. Saturating stall/flush event counters support performance analysis. It supersedes per-signal hand-written stage registers, and the hazard unit reads every stage through the tap outputs.

## Interface
Parameters:
- `WIDTH`, default 24: control word width in bits.
- `STAGES`, default 3: number of register stages, minimum 1. Stage 0 = decode→exec register; stage `STAGES-1` = writeback register.
- `BUBBLE_VALUE`, default `'0`: `WIDTH`-bit word loaded on reset, flush and bubble insertion.
- `CNT_W`, default 16: counter width.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_ctrl` in `WIDTH`: decoded control word from the decode stage.
- `i_valid` in 1: `i_ctrl` holds a real instruction.
- `i_stall` in `STAGES`: bit k requests stage k to hold.
- `i_flush` in `STAGES`: bit k clears stage k to a bubble.
- `i_cnt_clr` in 1: synchronous clear of both counters.
- `o_stage_ctrl` out `STAGES*WIDTH`: flat taps; bits `[k*WIDTH +: WIDTH]` = stage k word.
- `o_stage_valid` out `STAGES`: valid bit of each stage.
- `o_src_stall` out 1: decode and fetch must hold (equals effective stall of stage 0).
- `o_stall_cnt` out `CNT_W`: cycles with `o_src_stall` = 1, saturating.
- `o_flush_cnt` out `CNT_W`: cycles with any `i_flush` bit set, saturating.

## Operation
- **Effective stall:** `es[k] = OR(i_stall[j])` for j = k..`STAGES-1`. A downstream stall always holds every upstream stage, so it cannot be overwritten. `o_src_stall = es[0]`, purely combinational.
- **Stage source:** stage 0 source is `{i_valid, i_ctrl}`; stage k>0 source is stage k-1.
- **Per-stage update priority** at each rising edge, highest first:
  1. `i_flush[k]`: valid←0, word←`BUBBLE_VALUE`.
  2. `es[k]`: hold.
  3. k>0 and `es[k-1]`: the upstream stage is held, so load a bubble (valid←0, word←`BUBBLE_VALUE`). This prevents duplication.
  4. Otherwise load the source.
- **Flush during downstream stall:** flush still wins; the stage becomes a bubble and stays one while held.
- **Stage 0 with `i_valid` = 0:** the stage loads `{0, i_ctrl}` as presented. The word is not forced to `BUBBLE_VALUE`; consumers must qualify with valid.
- **Stall counter:** increments when `o_src_stall` = 1 and the counter is below all-ones.
- **Flush counter:** increments when `|i_flush` = 1 and the counter is below all-ones.
- **Counter clear:** `i_cnt_clr` forces 0 and wins over increment.
- **Outputs:** all outputs except `o_src_stall` come directly from registers, with no combinational path from inputs.

## Timing
- **Reset (async, `i_rst` = 0):**
  - All `o_stage_valid` = 0.
  - All `o_stage_ctrl` = `BUBBLE_VALUE`.
  - `o_stall_cnt` = `o_flush_cnt` = 0.
  - `o_src_stall` follows `i_stall` combinationally even in reset.
- **Reset deassertion:** synchronous to `i_clk` is handled externally. The first edge after release performs a normal update.
- **Reset mid-operation:** all in-flight words are discarded immediately.
- **Latency:** with no stall or flush, a word captured at edge n appears at stage k after edge n+k. It is visible on `o_stage_ctrl[k]` from edge n+k until edge n+k+1.
- **Stall release:** a stage held for m cycles resumes advancing on the first edge with `es[k]` = 0. Nothing is lost or duplicated.
- **`STAGES` = 1:** the bubble-insert rule is unused; `o_src_stall = i_stall[0]`.
- **Counter saturation:** at all-ones the counters stay at all-ones until `i_cnt_clr`.

## Test plan
- **Reset mid-stream:** reset while all stages are valid with `BUBBLE_VALUE`=0 → all taps 0, valid 0, counters 0 immediately, without waiting for a clock edge.
- **Stream:** (`STAGES`=3, `WIDTH`=8) feed 0x11, 0x22, 0x33 valid on consecutive edges → stage 2 shows 0x11 after edge 3, 0x22 after edge 4, 0x33 after edge 5, all valid.
- **Stall insertion:** with pipe 0x33/0x22/0x11, assert `i_stall[0]` for 2 cycles → stage 0 holds 0x33. Stage 1 gets bubbles (valid 0) for 2 edges. `o_src_stall`=1 for exactly 2 cycles and `o_stall_cnt`=2. After release 0x33 reaches stage 1 once.
- **Downstream stall propagation:** `i_stall[2]`=1 only → all three stages hold, `o_src_stall`=1, and no word is dropped after release.
- **Flush beats stall:** `i_flush[0]` and `i_stall[0]` together with stage 0 = 0x44 → stage 0 becomes bubble (valid 0, word 0x00). `o_flush_cnt` increments by 1.
- **Counter saturation and clear:** `CNT_W`=4 with 20 stall cycles → `o_stall_cnt`=15. Then assert `i_cnt_clr` together with a stall → counter 0 on the next edge.

Source files
------------

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline with per-stage stall/flush, upstream stall propagation,
// downstream bubble insertion and saturating stall/flush event counters.
module ctrl_pipe_chain #(
   parameter int                 WIDTH        = 24,
   parameter int                 STAGES       = 3,
   parameter logic [WIDTH-1:0]   BUBBLE_VALUE = '0,
   parameter int                 CNT_W        = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [WIDTH-1:0]          i_ctrl,
   input  logic                      i_valid,
   input  logic [STAGES-1:0]         i_stall,
   input  logic [STAGES-1:0]         i_flush,
   input  logic                      i_cnt_clr,
   output logic [STAGES*WIDTH-1:0]   o_stage_ctrl,
   output logic [STAGES-1:0]         o_stage_valid,
   output logic                      o_src_stall,
   output logic [CNT_W-1:0]          o_stall_cnt,
   output logic [CNT_W-1:0]          o_flush_cnt
);

   logic [STAGES-1:0] es;
   logic [STAGES-1:0] up_held;
   logic [WIDTH-1:0]  src_ctrl [STAGES];
   logic [STAGES-1:0] src_valid;

   logic [WIDTH-1:0]  ctrl_q   [STAGES];
   logic [WIDTH-1:0]  ctrl_d   [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_d;

   // A stall anywhere downstream holds every stage above it.
   always_comb begin
      logic acc;
      acc = 1'b0;
      es  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc   = acc | i_stall[k];
         es[k] = acc;
      end
   end

   always_comb begin
      src_ctrl[0]  = i_ctrl;
      src_valid[0] = i_valid;
      up_held[0]   = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         src_ctrl[k]  = ctrl_q[k-1];
         src_valid[k] = valid_q[k-1];
         up_held[k]   = es[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ctrl_d[k]  = ctrl_q[k];
         valid_d[k] = valid_q[k];
         if (i_flush[k]) begin
            ctrl_d[k]  = BUBBLE_VALUE;
            valid_d[k] = 1'b0;
         end else if (es[k]) begin
            ctrl_d[k]  = ctrl_q[k];
            valid_d[k] = valid_q[k];
         end else if (up_held[k]) begin
            // Upstream is frozen: feed a bubble so its word is not duplicated.
            ctrl_d[k]  = BUBBLE_VALUE;
            valid_d[k] = 1'b0;
         end else begin
            ctrl_d[k]  = src_ctrl[k];
            valid_d[k] = src_valid[k];
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (i_cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (es[0] && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if ((|i_flush) && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int k = 0; k < STAGES; k++) ctrl_q[k] <= BUBBLE_VALUE;
         valid_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) ctrl_q[k] <= ctrl_d[k];
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      o_stage_ctrl = '0;
      for (int k = 0; k < STAGES; k++) o_stage_ctrl[k*WIDTH +: WIDTH] = ctrl_q[k];
   end

   assign o_stage_valid = valid_q;
   assign o_src_stall   = es[0];
   assign o_stall_cnt   = stall_cnt_q;
   assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain (STAGES=3, WIDTH=8, CNT_W=4): scenario tasks plus
// an in-order scoreboard of words expected to leave the last stage.
module tb_ctrl_pipe_chain;

   localparam int W = 8;
   localparam int S = 3;
   localparam int C = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [W-1:0]    ctrl = '0;
   logic            valid = 1'b0;
   logic [S-1:0]    stall = '0;
   logic [S-1:0]    flush = '0;
   logic            cnt_clr = 1'b0;
   logic [S*W-1:0]  stage_ctrl;
   logic [S-1:0]    stage_valid;
   logic            src_stall;
   logic [C-1:0]    stall_cnt;
   logic [C-1:0]    flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] sb_q [$];
   logic         held = 1'b0;

   ctrl_pipe_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VALUE('0), .CNT_W(C)) dut (
      .i_clk(clk), .i_rst(rst), .i_ctrl(ctrl), .i_valid(valid),
      .i_stall(stall), .i_flush(flush), .i_cnt_clr(cnt_clr),
      .o_stage_ctrl(stage_ctrl), .o_stage_valid(stage_valid),
      .o_src_stall(src_stall), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Last-stage monitor: a valid word is new unless stage 2 was held at the last edge.
   always @(negedge clk) begin
      if (!rst) begin
         held = 1'b0;
      end else begin
         if (stage_valid[2] && !held) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got 0x%02h, required no output", stage_ctrl[2*W +: W]);
            end else begin
               logic [W-1:0] exp;
               exp = sb_q.pop_front();
               if (stage_ctrl[2*W +: W] !== exp) begin
                  n_fail++;
                  $display("FAIL sb_order: got 0x%02h, required 0x%02h", stage_ctrl[2*W +: W], exp);
               end
            end
         end
         held = stall[2];
      end
   end

   // Drive one cycle of inputs, record words that stage 0 will capture, then step one edge.
   task automatic cyc(input logic v, input logic [W-1:0] c, input logic [S-1:0] st,
                      input logic [S-1:0] fl, input logic clr);
      valid = v; ctrl = c; stall = st; flush = fl; cnt_clr = clr;
      if (v && !fl[0] && (st == '0)) sb_q.push_back(c);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      stall = 3'b100; #1;
      n_checks++;
      if (stage_valid !== 3'b000 || stage_ctrl !== 24'h000000) begin
         n_fail++;
         $display("FAIL reset_stages: got valid=%b ctrl=0x%06h, required 000/0x000000", stage_valid, stage_ctrl);
      end
      n_checks++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_counters: got %0d/%0d, required 0/0", stall_cnt, flush_cnt);
      end
      n_checks++;
      if (src_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_src_stall: got %b, required 1", src_stall);
      end
      stall = 3'b000; #1;
      n_checks++;
      if (src_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_src_stall_low: got %b, required 0", src_stall);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_stream();
      cyc(1, 8'h11, 0, 0, 0);
      cyc(1, 8'h22, 0, 0, 0);
      cyc(1, 8'h33, 0, 0, 0);
      n_checks++;
      if (stage_ctrl !== 24'h112233 || stage_valid !== 3'b111) begin
         n_fail++;
         $display("FAIL stream_taps: got 0x%06h/%b, required 0x112233/111", stage_ctrl, stage_valid);
      end
   endtask

   task automatic test_stall_insertion();
      logic [S*W-1:0] exp_c [2];
      logic [S-1:0]   exp_v [2];
      exp_c[0] = 24'h220033; exp_v[0] = 3'b101;
      exp_c[1] = 24'h000033; exp_v[1] = 3'b001;
      for (int i = 0; i < 2; i++) begin
         valid = 1; ctrl = 8'h55; stall = 3'b001; flush = 0; cnt_clr = 0; #1;
         n_checks++;
         if (src_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_src_%0d: got %b, required 1", i, src_stall);
         end
         cyc(1, 8'h55, 3'b001, 0, 0);
         n_checks++;
         if (stage_ctrl !== exp_c[i] || stage_valid !== exp_v[i]) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got 0x%06h/%b, required 0x%06h/%b",
                     i, stage_ctrl, stage_valid, exp_c[i], exp_v[i]);
         end
      end
      n_checks++;
      if (stall_cnt !== 4'd2) begin
         n_fail++;
         $display("FAIL stall_cnt: got %0d, required 2", stall_cnt);
      end
      valid = 1; ctrl = 8'h66; stall = 0; #1;
      n_checks++;
      if (src_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release_src: got %b, required 0", src_stall);
      end
      cyc(1, 8'h66, 0, 0, 0);
      n_checks++;
      if (stage_ctrl !== 24'h003366 || stage_valid !== 3'b011) begin
         n_fail++;
         $display("FAIL stall_release: got 0x%06h/%b, required 0x003366/011", stage_ctrl, stage_valid);
      end
      cyc(0, 8'h00, 0, 0, 0);
      n_checks++;
      if (stage_ctrl !== 24'h336600 || stage_valid !== 3'b110) begin
         n_fail++;
         $display("FAIL stall_no_dup: got 0x%06h/%b, required 0x336600/110", stage_ctrl, stage_valid);
      end
   endtask

   task automatic test_downstream_stall();
      cyc(1, 8'hA1, 0, 0, 0);
      cyc(1, 8'hA2, 0, 0, 0);
      cyc(1, 8'hA3, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         valid = 1; ctrl = 8'hB0; stall = 3'b100; flush = 0; #1;
         n_checks++;
         if (src_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL ds_src_%0d: got %b, required 1", i, src_stall);
         end
         cyc(1, 8'hB0, 3'b100, 0, 0);
         n_checks++;
         if (stage_ctrl !== 24'hA1A2A3 || stage_valid !== 3'b111) begin
            n_fail++;
            $display("FAIL ds_hold_%0d: got 0x%06h/%b, required 0xa1a2a3/111", i, stage_ctrl, stage_valid);
         end
      end
      n_checks++;
      if (stall_cnt !== 4'd5) begin
         n_fail++;
         $display("FAIL ds_stall_cnt: got %0d, required 5", stall_cnt);
      end
      cyc(1, 8'hB1, 0, 0, 0);
      n_checks++;
      if (stage_ctrl !== 24'hA2A3B1 || stage_valid !== 3'b111) begin
         n_fail++;
         $display("FAIL ds_release: got 0x%06h/%b, required 0xa2a3b1/111", stage_ctrl, stage_valid);
      end
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0);
   endtask

   task automatic test_flush_beats_stall();
      cyc(1, 8'h44, 0, 0, 0);
      n_checks++;
      if (stage_ctrl[W-1:0] !== 8'h44 || stage_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_setup: got 0x%02h/%b, required 0x44/1", stage_ctrl[W-1:0], stage_valid[0]);
      end
      void'(sb_q.pop_back());
      cyc(0, 8'h00, 3'b001, 3'b001, 0);
      n_checks++;
      if (stage_ctrl[W-1:0] !== 8'h00 || stage_valid[1:0] !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_stage0: got 0x%02h/%b, required 0x00/00", stage_ctrl[W-1:0], stage_valid[1:0]);
      end
      n_checks++;
      if (flush_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL flush_cnt: got %0d, required 1", flush_cnt);
      end
   endtask

   task automatic test_saturation();
      cyc(0, 8'h00, 0, 0, 1);
      n_checks++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL cnt_clr: got %0d/%0d, required 0/0", stall_cnt, flush_cnt);
      end
      for (int i = 0; i < 20; i++) cyc(0, 8'h00, 3'b001, 0, 0);
      n_checks++;
      if (stall_cnt !== 4'hF) begin
         n_fail++;
         $display("FAIL cnt_saturate: got %0d, required 15", stall_cnt);
      end
      cyc(0, 8'h00, 3'b001, 0, 1);
      n_checks++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL cnt_clr_wins: got %0d/%0d, required 0/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_reset_midstream();
      cyc(0, 8'h00, 3'b010, 0, 0);
      cyc(1, 8'hC1, 0, 0, 0);
      cyc(1, 8'hC2, 0, 0, 0);
      cyc(1, 8'hC3, 0, 0, 0);
      n_checks++;
      if (stage_valid !== 3'b111 || stall_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL mid_setup: got %b/%0d, required 111/1", stage_valid, stall_cnt);
      end
      #2 rst = 1'b0; stall = 3'b001; #1;
      sb_q.delete();
      n_checks++;
      if (stage_ctrl !== 24'h000000 || stage_valid !== 3'b000 ||
          stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || src_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: got 0x%06h/%b cnt %0d/%0d src %b, required 0x000000/000 cnt 0/0 src 1",
                  stage_ctrl, stage_valid, stall_cnt, flush_cnt, src_stall);
      end
      stall = 3'b000; rst = 1'b1;
      cyc(1, 8'hD1, 0, 0, 0);
      n_checks++;
      if (stage_ctrl !== 24'h0000D1 || stage_valid !== 3'b001) begin
         n_fail++;
         $display("FAIL mid_resume: got 0x%06h/%b, required 0x0000d1/001", stage_ctrl, stage_valid);
      end
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_insertion();
      test_downstream_stall();
      test_flush_beats_stall();
      test_saturation();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
